sar_conv_sequencer: RTL and testbench



---
 rtl/sar_conv_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_sar_conv_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_conv_sequencer.sv
// sar_conv_sequencer: S&H / calibration / SAR binary-search sequencer
// Optional: define SAR_AVG_EN to report the average of 4 conversions.
module sar_conv_sequencer #(
    parameter int NBITS         = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int CAL_CYCLES    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             cal_req,
    input  logic             cmp,
    input  logic             result_ready,
    input  logic             ovr_clr,
    output logic             sh_sample,
    output logic             comp_cal,
    output logic             comp_en_n,
    output logic [NBITS-1:0] dac_code,
    output logic [NBITS-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int CMAX0 = (SAMPLE_CYCLES > SETTLE_CYCLES) ?
                           SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CMAX  = (CAL_CYCLES > CMAX0) ? CAL_CYCLES : CMAX0;
    localparam int CW    = $clog2(CMAX + 1);
    localparam int BW    = (NBITS > 1) ? $clog2(NBITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CAL,
        SAMPLE,
        CONVERT,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [BW-1:0]    bit_q;
    logic [NBITS-1:0] code_q;
    logic             cal_pend_q;

    logic             cal_due;
    logic             enter_cal;
    logic             cal_last;
    logic             smp_last;
    logic             set_last;
    logic             last_bit;
    logic             last_pass;
    logic             wr_res;
    logic             ovr_set;
    logic [NBITS-1:0] final_code;

    assign cal_due   = cal_pend_q | cal_req;
    assign enter_cal = (state_d == CAL) && (state_q != CAL);
    assign cal_last  = (cnt_q == CW'(CAL_CYCLES - 1));
    assign smp_last  = (cnt_q == CW'(SAMPLE_CYCLES - 1));
    assign set_last  = (cnt_q == CW'(SETTLE_CYCLES - 1));
    assign last_bit  = (bit_q == '0);
    assign wr_res    = (state_q == DONE) && last_pass;
    assign ovr_set   = wr_res && result_valid && !result_ready;

`ifdef SAR_AVG_EN
    logic [1:0]       pass_q;
    logic [NBITS+1:0] acc_q;
    logic [NBITS+1:0] acc_sum;

    assign last_pass  = (pass_q == 2'd3);
    assign acc_sum    = acc_q + {2'b00, code_q};
    assign final_code = acc_sum[NBITS+1:2];

    // Accumulate each pass; cleared when idle or after the 4th pass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q <= '0;
            acc_q  <= '0;
        end else if (state_q == IDLE) begin
            pass_q <= '0;
            acc_q  <= '0;
        end else if (state_q == DONE) begin
            if (last_pass) begin
                pass_q <= '0;
                acc_q  <= '0;
            end else begin
                pass_q <= pass_q + 2'd1;
                acc_q  <= acc_sum;
            end
        end
    end
`else
    assign last_pass  = 1'b1;
    assign final_code = code_q;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start || cont) begin
                    state_d = cal_due ? CAL : SAMPLE;
                end
            end
            CAL: begin
                if (cal_last) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (smp_last) begin
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                if (set_last && last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!last_pass) begin
                    state_d = SAMPLE;
                end else if (cont) begin
                    state_d = cal_due ? CAL : SAMPLE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        sh_sample = (state_q == SAMPLE);
        comp_cal  = (state_q == CAL);
        comp_en_n = (state_q != CONVERT);
        busy      = (state_q != IDLE);
        dac_code  = '0;
        if (state_q == CONVERT) begin
            dac_code = code_q | (NBITS'(1) << bit_q);
        end
    end

    // Phase counter: restarts on every state change and every bit trial
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if (state_q == CONVERT && set_last) begin
            cnt_q <= '0;
        end else if (state_q != IDLE) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Binary search: keep the trial bit when the comparator says so
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= '0;
            bit_q  <= BW'(NBITS - 1);
        end else if (state_q == SAMPLE) begin
            code_q <= '0;
            bit_q  <= BW'(NBITS - 1);
        end else if (state_q == CONVERT && set_last) begin
            if (cmp) begin
                code_q[bit_q] <= 1'b1;
            end
            bit_q <= bit_q - BW'(1);
        end
    end

    // Calibration request is held until CAL is entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cal_pend_q <= 1'b0;
        end else begin
            cal_pend_q <= enter_cal ? 1'b0 : cal_due;
        end
    end

    // Result handshake and sticky overrun (set beats clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (wr_res) begin
                result       <= final_code;
                result_valid <= 1'b1;
            end else if (result_ready) begin
                result_valid <= 1'b0;
            end
            overrun <= ovr_set | (overrun & ~ovr_clr);
        end
    end

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// tb_sar_conv_sequencer: directed bench with an offset-based reference
// model compared every cycle, plus literal checks on latency and codes.
module tb_sar_conv_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       cal_req = 1'b0;
    logic       cmp;
    logic       result_ready = 1'b0;
    logic       ovr_clr = 1'b0;
    logic       sh_sample;
    logic       comp_cal;
    logic       comp_en_n;
    logic [7:0] dac_code;
    logic [7:0] result;
    logic       result_valid;
    logic       busy;
    logic       overrun;

    sar_conv_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cont         (cont),
        .cal_req      (cal_req),
        .cmp          (cmp),
        .result_ready (result_ready),
        .ovr_clr      (ovr_clr),
        .sh_sample    (sh_sample),
        .comp_cal     (comp_cal),
        .comp_en_n    (comp_en_n),
        .dac_code     (dac_code),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Analog front-end stand-in: held input code vs DAC, or a tied level
    logic [7:0] vin = 8'hA5;
    bit         tie_en = 1'b0;
    bit         tie_v = 1'b0;
    assign cmp = tie_en ? tie_v : (vin >= dac_code);

    int checks = 0;
    int failures = 0;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic int exp_code();
        if (tie_en) return tie_v ? 255 : 0;
        return int'(vin);
    endfunction

    function automatic int conv_len(bit wc);
        return (wc ? 8 : 0) + 4 + 8 * 2 + 1;
    endfunction

    // Trial k: kept upper bits of the final code plus the bit under test
    function automatic int trial(int k);
        int m;
        m = (255 << (8 - k)) & 255;
        return (exp_code() & m) | (128 >> k);
    endfunction

    // Reference model: conversion tracked as an edge offset from its start
    bit         m_act;
    int         m_off;
    bit         m_wcal;
    bit         m_pend;
    bit         m_rv;
    bit         m_ovr;
    logic [7:0] m_res;
    bit         m_wr;
    bit         m_go;
    bit         m_set;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_off = 0; m_wcal = 0; m_pend = 0;
            m_rv = 0; m_ovr = 0; m_res = 8'h00;
        end else begin
            m_wr = 0;
            m_go = 0;
            m_set = 0;
            if (m_act) begin
                if (m_off + 1 == conv_len(m_wcal)) begin
                    m_wr = 1;
                    m_act = 0;
                    if (cont) m_go = 1;
                end else begin
                    m_off++;
                end
            end else if (start || cont) begin
                m_go = 1;
            end
            if (m_wr) begin
                m_set = m_rv && !result_ready;
                m_rv = 1;
                m_res = 8'(exp_code());
            end else if (result_ready) begin
                m_rv = 0;
            end
            m_ovr = m_set ? 1'b1 : (ovr_clr ? 1'b0 : m_ovr);
            if (m_go) begin
                m_act = 1;
                m_off = 0;
                m_wcal = m_pend || cal_req;
                m_pend = m_wcal ? 1'b0 : (m_pend || cal_req);
            end else begin
                m_pend = m_pend || cal_req;
            end
        end
    end

    // Every-cycle comparison against the model
    int o;
    bit cv;
    always @(negedge clk) begin
        o = m_off - (m_wcal ? 8 : 0);
        cv = m_act && o >= 4 && o < 20;
        chk("busy", busy, m_act);
        chk("comp_cal", comp_cal, m_act && o < 0);
        chk("sh_sample", sh_sample, m_act && o >= 0 && o < 4);
        chk("comp_en_n", comp_en_n, !cv);
        chk("dac_code", dac_code, cv ? trial((o - 4) / 2) : 0);
        chk("result", result, m_res);
        chk("result_valid", result_valid, m_rv);
        chk("overrun", overrun, m_ovr);
    end

    // Phase monitors used by the literal checks
    int         sh_cnt;
    int         cal_cnt;
    int         rv_cnt;
    logic [7:0] trials [$];
    always @(negedge clk) begin
        if (sh_sample) sh_cnt++;
        if (comp_cal) cal_cnt++;
        if (result_valid) rv_cnt++;
        if (!comp_en_n) trials.push_back(dac_code);
    end

    logic [7:0] lit [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0,
                            8'hA8, 8'hA4, 8'hA6, 8'hA5};

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_mon();
        sh_cnt = 0;
        cal_cnt = 0;
        rv_cnt = 0;
        trials.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_rv(output int lat);
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (result_valid) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) chk("wait_rv_timeout", 0, 1);
    endtask

    task automatic wait_done();
        bit hit;
        hit = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy && comp_en_n && !sh_sample && !comp_cal) begin
                hit = 1;
                break;
            end
            step();
        end
        if (!hit) chk("wait_done_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) step();
        chk("wait_idle", busy, 0);
    endtask

    task automatic ack();
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        chk("ack_rv", result_valid, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    int lat;
    initial begin
        repeat (3) step();
        chk("rst_result", result, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_en_n", comp_en_n, 1);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        step();

        // Single conversion of 0xA5
        vin = 8'hA5;
        clr_mon();
        pulse_start();
        wait_rv(lat);
        chk("A_lat", lat, 21);
        chk("A_res", result, 8'hA5);
        chk("A_busy", busy, 0);
        chk("A_sh", sh_cnt, 4);
        chk("A_ntr", trials.size(), 16);
        if (trials.size() == 16) begin
            for (int k = 0; k < 8; k++) begin
                chk("A_tr_a", trials[2*k], lit[k]);
                chk("A_tr_b", trials[2*k+1], lit[k]);
            end
        end
        step();
        chk("A_hold", result_valid, 1);
        ack();

        // Comparator tied high, then low
        tie_en = 1'b1;
        tie_v = 1'b1;
        clr_mon();
        pulse_start();
        wait_rv(lat);
        chk("B_ff", result, 8'hFF);
        chk("B_sh1", sh_cnt, 4);
        ack();
        tie_v = 1'b0;
        clr_mon();
        pulse_start();
        wait_rv(lat);
        chk("B_00", result, 8'h00);
        chk("B_sh0", sh_cnt, 4);
        ack();
        tie_en = 1'b0;

        // Calibration with start in the same clock, then without
        vin = 8'h3E;
        clr_mon();
        cal_req = 1'b1;
        start = 1'b1;
        step();
        cal_req = 1'b0;
        start = 1'b0;
        wait_rv(lat);
        chk("C_lat", lat, 29);
        chk("C_cal", cal_cnt, 8);
        chk("C_res", result, 8'h3E);
        ack();
        clr_mon();
        pulse_start();
        wait_rv(lat);
        chk("C2_lat", lat, 21);
        chk("C2_cal", cal_cnt, 0);
        ack();

        // Continuous mode, overwrite without acceptance
        vin = 8'h5A;
        cont = 1'b1;
        wait_rv(lat);
        chk("D_res1", result, 8'h5A);
        chk("D_ovr1", overrun, 0);
        vin = 8'h3C;
        wait_done();
        step();
        chk("D_res2", result, 8'h3C);
        chk("D_ovr2", overrun, 1);
        cont = 1'b0;
        wait_idle();
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("D_clr", overrun, 0);
        ack();

        // Overwrite accepted in the same clock
        vin = 8'h11;
        cont = 1'b1;
        wait_rv(lat);
        vin = 8'h22;
        wait_done();
        result_ready = 1'b1;
        cont = 1'b0;
        step();
        result_ready = 1'b0;
        chk("D2_ovr", overrun, 0);
        chk("D2_rv", result_valid, 1);
        chk("D2_res", result, 8'h22);
        wait_idle();
        ack();

        // Asynchronous reset mid-conversion
        vin = 8'h77;
        pulse_start();
        repeat (8) step();
        #2 rst_n = 1'b0;
        #1;
        chk("E_busy", busy, 0);
        chk("E_en_n", comp_en_n, 1);
        chk("E_dac", dac_code, 0);
        chk("E_sh", sh_sample, 0);
        chk("E_cal", comp_cal, 0);
        chk("E_res", result, 0);
        chk("E_rv", result_valid, 0);
        chk("E_ovr", overrun, 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        pulse_start();
        wait_rv(lat);
        chk("E2_lat", lat, 21);
        chk("E2_res", result, 8'h77);
        ack();

        // Start pulses while busy are ignored
        vin = 8'hC3;
        result_ready = 1'b1;
        clr_mon();
        pulse_start();
        repeat (5) step();
        pulse_start();
        repeat (5) step();
        pulse_start();
        repeat (40) step();
        chk("F_rv_cnt", rv_cnt, 1);
        chk("F_busy", busy, 0);
        chk("F_res", result, 8'hC3);
        result_ready = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
